// File: rtl/sr_drift_bank.sv
// sr_drift_bank: N bounded per-channel drifts added to OMEGA_DT centres, updated one channel per clk_en through a shared datapath
module sr_drift_bank #(
   parameter int WIDTH = 18,
   parameter int NUM_CH = 5,
   parameter logic [NUM_CH*WIDTH-1:0] CENTER_PACKED = {WIDTH'(823), WIDTH'(643), WIDTH'(514), WIDTH'(354), WIDTH'(199)},
   parameter logic [NUM_CH*WIDTH-1:0] DRIFT_MAX_PACKED = {WIDTH'(51), WIDTH'(39), WIDTH'(26), WIDTH'(21), WIDTH'(13)},
   parameter int UPDATE_PERIOD = 400,
   parameter int STEP_BITS = 2,
   parameter logic [15:0] SEED_BASE = 16'hB5C3,
   parameter bit RANDOM_INIT = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clk_en,
   input  logic [1:0]               mode,
   input  logic                     freeze,
   input  logic                     reseed,
   input  logic [15:0]              seed_in,
   output logic [NUM_CH*WIDTH-1:0]  omega_dt_packed,
   output logic [NUM_CH*WIDTH-1:0]  drift_offset_packed,
   output logic                     update_strobe,
   output logic                     busy
);
   localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int CW = $clog2(UPDATE_PERIOD);
   localparam logic signed [WIDTH:0] ONE = (WIDTH+1)'(1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   function automatic logic [15:0] seed_of(input logic [15:0] s, input int k);
      logic [15:0] v;
      v = s ^ 16'(k * 'h9E37);
      return (v == '0) ? 16'd1 : v;
   endfunction

   function automatic logic signed [WIDTH-1:0] drift_of(input logic [15:0] l, input int k);
      int v;
      v = ((int'(l[15:11]) - 16) * int'(DRIFT_MAX_PACKED[k*WIDTH +: WIDTH])) >>> 4;
      return RANDOM_INIT ? WIDTH'(v) : '0;
   endfunction

   state_t                  r_state;
   logic [CW-1:0]           r_cnt;
   logic [IW-1:0]           r_idx;
   logic [1:0]              r_mode;
   logic                    r_busy;
   logic                    r_strobe;
   logic [15:0]             r_lfsr [NUM_CH];
   logic signed [WIDTH-1:0] r_drift [NUM_CH];
   logic [NUM_CH-1:0]       r_dir;

   logic                    w_last;
   logic [15:0]             w_seed;
   logic [15:0]             w_l;
   logic [15:0]             w_nl;
   logic signed [WIDTH:0]   w_d, w_m, w_s, w_up, w_dn, w_walk, w_tri, w_mag, w_home, w_nd;
   logic                    w_fit_up, w_fit_dn, w_at_hi, w_at_lo, w_tri_dir, w_ndir;

   assign w_last = (r_cnt == CW'(UPDATE_PERIOD - 1));
   assign w_seed = (seed_in == '0) ? SEED_BASE : seed_in;
   assign busy = r_busy;
   assign update_strobe = r_strobe;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_out
      assign drift_offset_packed[k*WIDTH +: WIDTH] = r_drift[k];
      assign omega_dt_packed[k*WIDTH +: WIDTH] = CENTER_PACKED[k*WIDTH +: WIDTH] + r_drift[k];
   end

   // shared channel datapath: next drift, direction and LFSR for channel r_idx (WIDTH+1 bits so bound tests never wrap)
   always_comb begin
      w_l = r_lfsr[r_idx];
      w_nl = {w_l[14:0], w_l[15] ^ w_l[13] ^ w_l[12] ^ w_l[10]};
      w_d = {r_drift[r_idx][WIDTH-1], r_drift[r_idx]};
      w_m = {1'b0, DRIFT_MAX_PACKED[r_idx*WIDTH +: WIDTH]};
      w_s = ONE + (WIDTH+1)'(w_l[STEP_BITS+1:2]);
      w_up = w_d + w_s;
      w_dn = w_d - w_s;
      w_fit_up = (w_up <= w_m);
      w_fit_dn = (w_dn >= -w_m);
      w_walk = w_l[0] ? (w_fit_up ? w_up : (w_fit_dn ? w_dn : w_d)) : (w_fit_dn ? w_dn : (w_fit_up ? w_up : w_d));
      w_at_hi = (w_d >= w_m);
      w_at_lo = (w_d <= -w_m);
      w_tri = r_dir[r_idx] ? (w_at_hi ? w_d - ONE : w_d + ONE) : (w_at_lo ? w_d + ONE : w_d - ONE);
      w_tri_dir = r_dir[r_idx] ? (!w_at_hi && (w_tri < w_m)) : (w_at_lo || (w_tri <= -w_m));
      w_mag = w_d[WIDTH] ? -w_d : w_d;
      w_home = (w_s >= w_mag) ? '0 : (w_d[WIDTH] ? w_up : w_dn);
      w_nd = (r_mode == 2'd0) ? w_walk : (r_mode == 2'd1) ? w_d : (r_mode == 2'd2) ? w_tri : w_home;
      w_ndir = (r_mode == 2'd2) ? w_tri_dir : r_dir[r_idx];
   end

   // sweep sequencer: period counter in IDLE, one channel per clk_en in RUN, one-clk strobe in DONE
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt <= '0;
         r_idx <= '0;
         r_mode <= 2'd0;
         r_busy <= 1'b0;
         r_strobe <= 1'b0;
      end else if (reseed) begin
         r_state <= IDLE;
         r_cnt <= '0;
         r_idx <= '0;
         r_busy <= 1'b0;
         r_strobe <= 1'b0;
      end else begin
         r_strobe <= 1'b0;
         case (r_state)
            IDLE: if (clk_en && !freeze) begin
               r_cnt <= w_last ? '0 : r_cnt + 1'b1;
               if (w_last) begin
                  r_state <= RUN;
                  r_busy <= 1'b1;
                  r_mode <= mode;
                  r_idx <= '0;
               end
            end
            RUN: if (clk_en) begin
               r_idx <= r_idx + 1'b1;
               if (r_idx == IW'(NUM_CH - 1)) begin
                  r_state <= DONE;
                  r_busy <= 1'b0;
                  r_strobe <= 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // per-channel state: seeded on reset/reseed, written back for channel r_idx on each RUN clk_en
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_dir <= '1;
         for (int k = 0; k < NUM_CH; k++) begin
            r_lfsr[k] <= seed_of(SEED_BASE, k);
            r_drift[k] <= drift_of(seed_of(SEED_BASE, k), k);
         end
      end else if (reseed) begin
         r_dir <= '1;
         for (int k = 0; k < NUM_CH; k++) begin
            r_lfsr[k] <= seed_of(w_seed, k);
            r_drift[k] <= drift_of(seed_of(w_seed, k), k);
         end
      end else if (r_state == RUN && clk_en) begin
         r_lfsr[r_idx] <= w_nl;
         r_drift[r_idx] <= w_nd[WIDTH-1:0];
         r_dir[r_idx] <= w_ndir;
      end
   end
endmodule

// File: tb/tb_sr_drift_bank.sv
// tb_sr_drift_bank: directed and randomized checks of sr_drift_bank against an arithmetic reference model
module tb_sr_drift_bank;
   localparam int W = 18;
   localparam int N = 5;
   localparam int P = 8;
   localparam int SB = 'hB5C3;

   int cen [N] = '{199, 354, 514, 643, 823};
   int maxv [N] = '{13, 21, 26, 39, 51};

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic clk_en = 1'b0;
   logic [1:0] mode = 2'd0;
   logic freeze = 1'b0;
   logic reseed = 1'b0;
   logic [15:0] seed_in = 16'd0;
   logic [N*W-1:0] om0, dr0, om1, dr1;
   logic stb0, bsy0, stb1, bsy1;

   int md [2][N];
   int ml [2][N];
   bit mup [2][N];
   int m_cnt, m_pos, m_mode;
   bit m_busy, m_strobe;
   int vectors = 0;
   int miscompares = 0;

   sr_drift_bank #(.UPDATE_PERIOD(P), .RANDOM_INIT(1'b0)) u_dut (
      .clk(clk), .rst(rst), .clk_en(clk_en), .mode(mode), .freeze(freeze), .reseed(reseed), .seed_in(seed_in),
      .omega_dt_packed(om0), .drift_offset_packed(dr0), .update_strobe(stb0), .busy(bsy0));

   sr_drift_bank #(.UPDATE_PERIOD(P), .RANDOM_INIT(1'b1)) u_dut_ri (
      .clk(clk), .rst(rst), .clk_en(clk_en), .mode(mode), .freeze(freeze), .reseed(reseed), .seed_in(seed_in),
      .omega_dt_packed(om1), .drift_offset_packed(dr1), .update_strobe(stb1), .busy(bsy1));

   always #5 clk = ~clk;

   function automatic int seed_k(int s, int k);
      int v;
      v = (s ^ (k * 'h9E37)) & 'hFFFF;
      return (v == 0) ? 1 : v;
   endfunction

   // bank 0 starts at zero drift, bank 1 at floor((top5 - 16) * M / 16)
   function automatic int init_d(int b, int l, int k);
      int v;
      if (b == 0) return 0;
      v = ((l >> 11) - 16) * maxv[k];
      return (v >= 0) ? v / 16 : -((15 - v) / 16);
   endfunction

   task automatic m_init(int seed);
      for (int b = 0; b < 2; b++)
         for (int k = 0; k < N; k++) begin
            ml[b][k] = seed_k(seed, k);
            md[b][k] = init_d(b, ml[b][k], k);
            mup[b][k] = 1'b1;
         end
      m_cnt = 0;
      m_pos = 0;
      m_busy = 1'b0;
      m_strobe = 1'b0;
   endtask

   function automatic void m_chan(int b, int k);
      int d, m, l, s, t;
      d = md[b][k];
      m = maxv[k];
      l = ml[b][k];
      s = 1 + ((l >> 2) & 3);
      case (m_mode)
         0: begin
            if (l & 1) d = (d + s <= m) ? d + s : (d - s >= -m) ? d - s : d;
            else d = (d - s >= -m) ? d - s : (d + s <= m) ? d + s : d;
         end
         2: begin
            if (mup[b][k] && d >= m) mup[b][k] = 1'b0;
            else if (!mup[b][k] && d <= -m) mup[b][k] = 1'b1;
            d = mup[b][k] ? d + 1 : d - 1;
            if (d >= m) mup[b][k] = 1'b0;
            if (d <= -m) mup[b][k] = 1'b1;
         end
         3: begin
            t = (d < 0) ? -d : d;
            t = (s < t) ? s : t;
            d = (d < 0) ? d + t : d - t;
         end
         default: ;
      endcase
      md[b][k] = d;
      ml[b][k] = ((l << 1) | ($countones(l & 'hB400) & 1)) & 'hFFFF;
   endfunction

   task automatic m_edge();
      if (reseed) m_init((seed_in == 16'd0) ? SB : int'(seed_in));
      else if (m_strobe) m_strobe = 1'b0;
      else if (m_busy) begin
         if (clk_en) begin
            m_chan(0, m_pos);
            m_chan(1, m_pos);
            m_pos++;
            if (m_pos == N) begin
               m_busy = 1'b0;
               m_strobe = 1'b1;
            end
         end
      end else if (clk_en && !freeze) begin
         if (m_cnt == P - 1) begin
            m_cnt = 0;
            m_busy = 1'b1;
            m_pos = 0;
            m_mode = int'(mode);
         end else m_cnt++;
      end
   endtask

   task automatic check();
      logic [N*W-1:0] ed, eo, gd, go;
      int v;
      for (int b = 0; b < 2; b++) begin
         gd = b ? dr1 : dr0;
         go = b ? om1 : om0;
         for (int k = 0; k < N; k++) begin
            ed[k*W +: W] = W'(md[b][k]);
            eo[k*W +: W] = W'(cen[k] + md[b][k]);
            v = int'(signed'(gd[k*W +: W]));
            vectors++;
            assert (v >= -maxv[k] && v <= maxv[k]) else begin
               miscompares++;
               $error("FAIL bound b%0d ch%0d got=%0d limit=%0d", b, k, v, maxv[k]);
            end
         end
         vectors++;
         assert (gd === ed) else begin
            miscompares++;
            $error("FAIL drift b%0d got=%h exp=%h", b, gd, ed);
         end
         vectors++;
         assert (go === eo) else begin
            miscompares++;
            $error("FAIL omega b%0d got=%h exp=%h", b, go, eo);
         end
      end
      vectors++;
      assert ({bsy1, bsy0} === {m_busy, m_busy}) else begin
         miscompares++;
         $error("FAIL busy got=%b%b exp=%b", bsy1, bsy0, m_busy);
      end
      vectors++;
      assert ({stb1, stb0} === {m_strobe, m_strobe}) else begin
         miscompares++;
         $error("FAIL strobe got=%b%b exp=%b", stb1, stb0, m_strobe);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      if (!rst) m_edge();
      #1;
      check();
   endtask

   task automatic wait_strobe();
      for (int t = 0; t < 200; t++) begin
         cyc();
         if (stb0) return;
      end
      vectors++;
      miscompares++;
      $error("FAIL strobe_timeout got=none exp=strobe within 200 clks");
   endtask

   task automatic run_sweeps(int n);
      for (int i = 0; i < n; i++) wait_strobe();
   endtask

   initial begin
      int gap, c, n;
      m_init(SB);
      m_mode = 0;
      repeat (3) cyc();
      rst = 1'b0;
      repeat (2) cyc();
      // triangle sweep from zero with clk_en held high
      mode = 2'd2;
      clk_en = 1'b1;
      run_sweeps(1);
      gap = 0;
      do begin
         cyc();
         gap++;
      end while (!stb0 && gap < 100);
      vectors++;
      assert (gap === 14) else begin
         miscompares++;
         $error("FAIL strobe_period got=%0d exp=14", gap);
      end
      run_sweeps(11);
      vectors++;
      assert (int'(signed'(dr0[W-1:0])) === 13) else begin
         miscompares++;
         $error("FAIL ch0_peak got=%0d exp=13", int'(signed'(dr0[W-1:0])));
      end
      // return to centre from the peak
      mode = 2'd3;
      run_sweeps(14);
      vectors++;
      assert (int'(signed'(dr0[W-1:0])) === 0) else begin
         miscompares++;
         $error("FAIL ch0_home got=%0d exp=0", int'(signed'(dr0[W-1:0])));
      end
      mode = 2'd2;
      run_sweeps(45);
      // freeze holds everything; release resumes the partial count
      mode = 2'd0;
      repeat (3 + $urandom_range(0, 6)) cyc();
      freeze = 1'b1;
      n = 0;
      for (int i = 0; i < 1000; i++) begin
         cyc();
         if (i >= 20 && stb0) n++;
      end
      vectors++;
      assert (n === 0) else begin
         miscompares++;
         $error("FAIL freeze_strobes got=%0d exp=0", n);
      end
      c = m_cnt;
      freeze = 1'b0;
      gap = 0;
      do begin
         cyc();
         gap++;
      end while (!stb0 && gap < 100);
      vectors++;
      assert (gap === P - c + N) else begin
         miscompares++;
         $error("FAIL resume_latency got=%0d exp=%0d", gap, P - c + N);
      end
      // reseed aborts a sweep at channel 2
      for (int t = 0; t < 100 && !(m_busy && m_pos == 2); t++) cyc();
      vectors++;
      assert (bsy0 === 1'b1) else begin
         miscompares++;
         $error("FAIL midsweep_busy got=%b exp=1", bsy0);
      end
      reseed = 1'b1;
      seed_in = 16'd0;
      cyc();
      reseed = 1'b0;
      vectors++;
      assert (bsy0 === 1'b0) else begin
         miscompares++;
         $error("FAIL reseed_busy got=%b exp=0", bsy0);
      end
      n = 0;
      for (int i = 0; i < 10; i++) begin
         cyc();
         if (stb0) n++;
      end
      vectors++;
      assert (n === 0) else begin
         miscompares++;
         $error("FAIL aborted_strobe got=%0d exp=0", n);
      end
      // seed that zeroes channel 1's LFSR and must be forced to 1
      reseed = 1'b1;
      seed_in = 16'h9E37;
      cyc();
      reseed = 1'b0;
      run_sweeps(20);
      // randomized traffic: gapped clk_en, freeze blips, mode changes, occasional reseed
      for (int i = 0; i < 30000; i++) begin
         clk_en = ($urandom_range(0, 3) != 0);
         freeze = ($urandom_range(0, 49) == 0);
         if (i % 600 == 0) mode = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
         reseed = ($urandom_range(0, 2999) == 0);
         seed_in = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
         cyc();
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
